fifo_control: RTL

//   Pointer/flag controller for the FIFO memory block. Converts push/pop requests into
//   wr_enable/rd_enable and wr_ptr/rd_ptr for the memory. Tracks fill level, flags

---
 rtl/fifo_control_if.sv | 33 +++
 rtl/fifo_control.sv | 65 ++++++
 2 files changed

// File: rtl/fifo_control_if.sv
// Request/status bundle between a FIFO controller and its users.
// The slave side is the controller; the master side issues push/pop and sets thresholds.
interface fifo_control_if #(
  parameter int address_width = 3
);
  logic                     push;
  logic                     pop;
  logic [address_width:0]   almost_full_thr;
  logic [address_width:0]   almost_empty_thr;
  logic                     wr_enable;
  logic                     rd_enable;
  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic                     valid_out;
  logic [address_width:0]   fill_level;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic                     fifo_error;

  modport master (
    output push, pop, almost_full_thr, almost_empty_thr,
    input  wr_enable, rd_enable, wr_ptr, rd_ptr, valid_out, fill_level,
    input  fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  push, pop, almost_full_thr, almost_empty_thr,
    output wr_enable, rd_enable, wr_ptr, rd_ptr, valid_out, fill_level,
    output fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/fifo_control.sv
// Pointer and flag controller for one FIFO memory: gates push/pop into memory strobes,
// keeps read/write pointers and an explicit fill count, and latches over/underflow.
module fifo_control #(
  parameter int address_width = 3
) (
  input logic           clk,
  input logic           reset,
  fifo_control_if.slave bus
);
  localparam int                     DEPTH_I = 2 ** address_width;
  localparam logic [address_width:0] DEPTH   = (address_width + 1)'(DEPTH_I);

  logic [address_width-1:0] r_wr_ptr;
  logic [address_width-1:0] r_rd_ptr;
  logic [address_width:0]   r_fill_level;
  logic                     r_valid_out;
  logic                     r_fifo_error;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;
  logic w_overflow;
  logic w_underflow;

  assign w_full      = (r_fill_level == DEPTH);
  assign w_empty     = (r_fill_level == '0);
  // Rejected requests are gated here, so they can never disturb pointers or level.
  assign w_wr_en     = bus.push & ~w_full;
  assign w_rd_en     = bus.pop & ~w_empty;
  assign w_overflow  = bus.push & w_full;
  assign w_underflow = bus.pop & w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill_level <= '0;
      r_valid_out  <= 1'b0;
      r_fifo_error <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + address_width'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + address_width'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_fill_level <= r_fill_level + (address_width + 1)'(1);
        2'b01:   r_fill_level <= r_fill_level - (address_width + 1)'(1);
        default: r_fill_level <= r_fill_level;
      endcase
      r_valid_out  <= w_rd_en;
      r_fifo_error <= r_fifo_error | w_overflow | w_underflow;
    end
  end

  assign bus.wr_enable    = w_wr_en;
  assign bus.rd_enable    = w_rd_en;
  assign bus.wr_ptr       = r_wr_ptr;
  assign bus.rd_ptr       = r_rd_ptr;
  assign bus.valid_out    = r_valid_out;
  assign bus.fill_level   = r_fill_level;
  assign bus.fifo_full    = w_full;
  assign bus.fifo_empty   = w_empty;
  assign bus.almost_full  = (r_fill_level >= bus.almost_full_thr);
  assign bus.almost_empty = (r_fill_level <= bus.almost_empty_thr);
  assign bus.fifo_error   = r_fifo_error;
endmodule
